t5_wbarb: RTL

T5_WBARB -- requirements
Module: t5_wbarb

---
 rtl/t5_pkg.sv | 14 +
 rtl/t5_wbarb_if.sv | 20 ++
 rtl/t5_wbarb.sv | 91 +++++++++
 3 files changed

// File: rtl/t5_pkg.sv
// Shared definitions for the t5 Wishbone arbiter.
//   arb_state_e  : arbiter FSM state encoding (idle / instruction grant / data grant)
//   SlimDefault  : default cap on consecutive data grants while an instruction request waits
package t5_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StIgnt = 2'd1,
    StDgnt = 2'd2
  } arb_state_e;

  localparam int unsigned SlimDefault = 4;

endpackage

// File: rtl/t5_wbarb_if.sv
// Simple Wishbone-style bus bundle.
//   adr : word address [31:2]        dto : write data (master -> slave)
//   sel : byte selects               stb : request strobe
//   wre : write enable               ack : transfer acknowledge (slave -> master)
//   dti : read data (slave -> master)
// master modport drives the request side, slave modport answers it.
interface t5_wbarb_if #(
  parameter int unsigned XLEN = 32
);
  logic [29:0]     adr;
  logic [XLEN-1:0] dto;
  logic [3:0]      sel;
  logic            stb;
  logic            wre;
  logic            ack;
  logic [XLEN-1:0] dti;

  modport master (output adr, dto, sel, stb, wre, input ack, dti);
  modport slave  (input adr, dto, sel, stb, wre, output ack, dti);
endinterface

// File: rtl/t5_wbarb.sv
// Two-master to one-slave Wishbone arbiter. Data requests win collisions, but after
// SLIM back-to-back data grants with an instruction request pending, the instruction
// master is served next so it cannot starve.
//   sys_clk : clock, rising edge
//   sys_rst : synchronous active-high reset
//   sys_ena : arbitration enable; low blocks new grants, in-flight grants still finish
//   iwb     : instruction master port (arbiter is its slave)
//   dwb     : data master port (arbiter is its slave)
//   mwb     : shared memory port (arbiter is the master)
module t5_wbarb
  import t5_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SLIM = SlimDefault
) (
  input logic        sys_clk,
  input logic        sys_rst,
  input logic        sys_ena,
  t5_wbarb_if.slave  iwb,
  t5_wbarb_if.slave  dwb,
  t5_wbarb_if.master mwb
);

  localparam logic [3:0] SlimCnt = 4'(SLIM);

  arb_state_e state_q;
  logic [3:0] scnt_q;   // consecutive data grants issued while iwb.stb was pending
  logic       starve;

  assign starve = (scnt_q == SlimCnt) && iwb.stb;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      scnt_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (sys_ena && dwb.stb && !starve) begin
            state_q <= StDgnt;
            if (!iwb.stb) begin
              scnt_q <= '0;
            end else if (scnt_q < SlimCnt) begin
              scnt_q <= scnt_q + 4'd1;
            end
          end else if (sys_ena && iwb.stb) begin
            state_q <= StIgnt;
            scnt_q  <= '0;
          end
        end
        // Leave on ack, or when the master aborts by dropping its strobe.
        StIgnt: if (mwb.ack || !iwb.stb) state_q <= StIdle;
        StDgnt: if (mwb.ack || !dwb.stb) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Shared port follows the granted master; everything is zero while idle.
  always_comb begin
    mwb.adr = '0;
    mwb.dto = '0;
    mwb.sel = '0;
    mwb.stb = 1'b0;
    mwb.wre = 1'b0;
    case (state_q)
      StIgnt: begin
        mwb.adr = iwb.adr;
        mwb.dto = iwb.dto;
        mwb.sel = iwb.sel;
        mwb.stb = iwb.stb;
        mwb.wre = iwb.wre;
      end
      StDgnt: begin
        mwb.adr = dwb.adr;
        mwb.dto = dwb.dto;
        mwb.sel = dwb.sel;
        mwb.stb = dwb.stb;
        mwb.wre = dwb.wre;
      end
      default: ;
    endcase
  end

  // Acks are forwarded in the same cycle; a stray ack while idle reaches nobody.
  assign iwb.ack = mwb.ack && (state_q == StIgnt) && iwb.stb;
  assign dwb.ack = mwb.ack && (state_q == StDgnt) && dwb.stb;
  assign iwb.dti = mwb.dti;
  assign dwb.dti = mwb.dti;

endmodule
